// File: rtl/data_unpack_stream.sv
// Word-to-packet unpacker: IN_W-bit words in, OUT_W-bit packets out, with frame-end
// zero-padded flush and synchronous clear. Define UNPACK_MSB_FIRST_EN for MSB-first bit order.
module data_unpack_stream #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 7
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic [IN_W-1:0]                    in_data,
  input  logic                               in_valid,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [OUT_W-1:0]                   out_data,
  output logic                               out_valid,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic [$clog2(IN_W+OUT_W+1)-1:0]    level
);

  localparam int BUF_W = IN_W + OUT_W - 1;
  localparam int LW    = $clog2(IN_W + OUT_W + 1);
  localparam logic [LW-1:0] IN_W_L  = LW'(IN_W);
  localparam logic [LW-1:0] OUT_W_L = LW'(OUT_W);

  typedef enum logic [1:0] {FILL, DRAIN, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [BUF_W-1:0]   bit_buf_reg, bit_buf_next;
  logic [LW-1:0]      level_reg, level_next;
  logic               last_pend_reg, last_pend_next;
  logic               in_ready_reg, out_valid_reg, out_last_reg;
  logic               in_fire, out_fire;
  logic [BUF_W-1:0]   word_ext;

  assign in_fire  = in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & out_ready;
  assign word_ext = BUF_W'(in_data);

  always_comb begin
    bit_buf_next   = bit_buf_reg;
    level_next     = level_reg;
    last_pend_next = last_pend_reg;
    state_next     = FILL;
    if (in_fire) begin
`ifdef UNPACK_MSB_FIRST_EN
      // Valid bits stay left-aligned; the new word lands just below them.
      bit_buf_next = bit_buf_reg | (word_ext << (LW'(OUT_W - 1) - level_reg));
`else
      bit_buf_next = bit_buf_reg | (word_ext << level_reg);
`endif
      level_next = level_reg + IN_W_L;
      if (in_last) last_pend_next = 1'b1;
    end else if (out_fire) begin
      if (state_reg == FLUSH) begin
        bit_buf_next   = '0;
        level_next     = '0;
        last_pend_next = 1'b0;
      end else begin
`ifdef UNPACK_MSB_FIRST_EN
        bit_buf_next = bit_buf_reg << OUT_W;
`else
        bit_buf_next = bit_buf_reg >> OUT_W;
`endif
        level_next = level_reg - OUT_W_L;
      end
    end
    // A frame that drains to exactly zero ends without a flush packet.
    if (level_next >= OUT_W_L) begin
      state_next = DRAIN;
    end else if (last_pend_next && (level_next != '0)) begin
      state_next = FLUSH;
    end else begin
      state_next     = FILL;
      last_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FILL;
      bit_buf_reg   <= '0;
      level_reg     <= '0;
      last_pend_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (clr) begin
      state_reg     <= FILL;
      bit_buf_reg   <= '0;
      level_reg     <= '0;
      last_pend_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_buf_reg   <= bit_buf_next;
      level_reg     <= level_next;
      last_pend_reg <= last_pend_next;
      in_ready_reg  <= (state_next == FILL);
      out_valid_reg <= (state_next != FILL);
      out_last_reg  <= (state_next == FLUSH) ||
                       ((state_next == DRAIN) && last_pend_next && (level_next == OUT_W_L));
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign level     = level_reg;
`ifdef UNPACK_MSB_FIRST_EN
  assign out_data  = bit_buf_reg[BUF_W-1 -: OUT_W];
`else
  assign out_data  = bit_buf_reg[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_data_unpack_stream.sv
// Bench for data_unpack_stream: bit-queue reference model checked every cycle,
// plus directed tests with literal expectations.
module tb_data_unpack_stream;
  localparam int IN_W  = 32;
  localparam int OUT_W = 7;
  localparam int LW    = $clog2(IN_W + OUT_W + 1);

`ifdef UNPACK_MSB_FIRST_EN
  localparam logic [OUT_W-1:0] P_F_RES  = 7'h78;
  localparam logic [OUT_W-1:0] P_A5     = 7'h52;
  localparam logic [OUT_W-1:0] P_F0     = 7'h78;
`else
  localparam logic [OUT_W-1:0] P_F_RES  = 7'h0F;
  localparam logic [OUT_W-1:0] P_A5     = 7'h25;
  localparam logic [OUT_W-1:0] P_F0     = 7'h00;
`endif
  localparam logic [IN_W-1:0] VEC [7] = '{32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF,
                                           32'h0F0F0F0F, 32'hC3A55A3C, 32'h80000001, 32'h7FFFFFFE};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic [LW-1:0]    level;

  data_unpack_stream #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stream as a bit queue, expected packets precomputed on word acceptance.
  bit               bitq[$];
  logic [OUT_W-1:0] exp_data[$];
  bit               exp_last[$];
  bit               exp_flush[$];
  int               model_level = 0;
  logic [OUT_W-1:0] rx_data[$];
  bit               rx_last[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] take_packet(int n);
    logic [OUT_W-1:0] p = '0;
    for (int j = 0; j < n; j++) begin
`ifdef UNPACK_MSB_FIRST_EN
      p[OUT_W-1-j] = bitq.pop_front();
`else
      p[j] = bitq.pop_front();
`endif
    end
    return p;
  endfunction

  function automatic void model_clear();
    bitq.delete(); exp_data.delete(); exp_last.delete(); exp_flush.delete();
    model_level = 0;
  endfunction

  function automatic void model_accept(logic [IN_W-1:0] w, bit last);
    logic [OUT_W-1:0] d;
    for (int i = 0; i < IN_W; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
      bitq.push_back(w[IN_W-1-i]);
`else
      bitq.push_back(w[i]);
`endif
    end
    model_level += IN_W;
    while (bitq.size() >= OUT_W) begin
      d = take_packet(OUT_W);
      exp_data.push_back(d);
      exp_last.push_back(last && (bitq.size() == 0));
      exp_flush.push_back(1'b0);
    end
    if (last && bitq.size() > 0) begin
      d = take_packet(bitq.size());
      exp_data.push_back(d);
      exp_last.push_back(1'b1);
      exp_flush.push_back(1'b1);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) model_clear();
    chk("level", 64'(level), 64'(model_level));
    chk("out_valid", 64'(out_valid), 64'(exp_data.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_data.size() == 0));
    if (out_valid && exp_data.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(exp_data[0]));
      chk("out_last", 64'(out_last), 64'(exp_last[0]));
    end
    if (!rst) begin
      if (clr) model_clear();
      else if (in_valid && in_ready) model_accept(in_data, in_last);
      else if (out_valid && out_ready && exp_data.size() != 0) begin
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        if (exp_flush[0]) model_level = 0;
        else model_level -= OUT_W;
        void'(exp_data.pop_front()); void'(exp_last.pop_front()); void'(exp_flush.pop_front());
      end
    end
  end

  task automatic send_word(input logic [IN_W-1:0] w, input bit last);
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    chk("send_wait_ready", 64'(in_ready), 64'd1);
    in_data = w; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    $display("word %08h last=%0d accepted", w, last);
  endtask

  task automatic wait_fill();
    int n = 0;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic clear_rx();
    rx_data.delete(); rx_last.delete();
  endtask

  initial begin
    logic [OUT_W-1:0] hold;
    int nlast;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    out_ready = 1'b1;

    // All-ones then all-zeros word
    clear_rx();
    send_word(32'hFFFFFFFF, 1'b0);
    wait_fill();
    chk("ones_count", 64'(rx_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx_data.size(); i++) chk("ones_pkt", 64'(rx_data[i]), 64'h7F);
    chk("ones_level", 64'(level), 64'd4);
    clear_rx();
    send_word(32'h00000000, 1'b0);
    wait_fill();
    chk("zeros_count", 64'(rx_data.size()), 64'd5);
    if (rx_data.size() == 5) begin
      chk("zeros_first", 64'(rx_data[0]), 64'(P_F_RES));
      for (int i = 1; i < 5; i++) chk("zeros_pkt", 64'(rx_data[i]), 64'h00);
    end
    chk("zeros_level", 64'(level), 64'd1);

    // Seven words, no frame end: 224 bits -> 32 packets
    pulse_clr();
    clear_rx();
    for (int i = 0; i < 7; i++) send_word(VEC[i], 1'b0);
    wait_fill();
    nlast = 0;
    foreach (rx_last[i]) nlast += int'(rx_last[i]);
    chk("seven_count", 64'(rx_data.size()), 64'd32);
    chk("seven_level", 64'(level), 64'd0);
    chk("seven_no_last", 64'(nlast), 64'd0);

    // Frame end with residual flush
    clear_rx();
    send_word(32'hFFFFFFFF, 1'b1);
    wait_fill();
    chk("frame_count", 64'(rx_data.size()), 64'd5);
    if (rx_data.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        chk("frame_pkt", 64'(rx_data[i]), 64'h7F);
        chk("frame_pkt_last", 64'(rx_last[i]), 64'd0);
      end
      chk("frame_flush", 64'(rx_data[4]), 64'(P_F_RES));
      chk("frame_flush_last", 64'(rx_last[4]), 64'd1);
    end
    chk("frame_level", 64'(level), 64'd0);

    // Backpressure for 5 cycles in DRAIN
    clear_rx();
    out_ready = 1'b0;
    send_word(32'hA5A5A5A5, 1'b0);
    hold = out_data;
    chk("bp_first", 64'(hold), 64'(P_A5));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", 64'(out_data), 64'(hold));
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    wait_fill();
    chk("bp_count", 64'(rx_data.size()), 64'd4);
    if (rx_data.size() > 0) chk("bp_rx0", 64'(rx_data[0]), 64'(P_A5));
    chk("bp_level", 64'(level), 64'd4);

    // clr in DRAIN with level 18 and frame end pending; clr beats out_fire
    pulse_clr();
    out_ready = 1'b0;
    send_word(32'hFFFFFFFF, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("clr_pre_level", 64'(level), 64'd18);
    chk("clr_pre_valid", 64'(out_valid), 64'd1);
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    // clr also drops a word offered in the same cycle
    in_data = 32'hFFFFFFFF; in_valid = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clr_drop_level", 64'(level), 64'd0);
    chk("clr_drop_valid", 64'(out_valid), 64'd0);

    // Bit-order probe
    clear_rx();
    send_word(32'hF0000000, 1'b0);
    wait_fill();
    if (rx_data.size() > 0) chk("order_first", 64'(rx_data[0]), 64'(P_F0));
    else chk("order_count", 64'(rx_data.size()), 64'd4);

    // Asynchronous reset mid-DRAIN
    out_ready = 1'b0;
    send_word(32'h12345678, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_arst_ready", 64'(in_ready), 64'd1);
    chk("post_arst_level", 64'(level), 64'd0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
